// File: rtl/des_key_sequencer.sv
// DES key-schedule and round-control sequencer for an iterative single-round datapath.
// Produces one 48-bit subkey per round cycle plus load/output strobes and a done pulse.
module des_key_sequencer #(
    parameter int unsigned OV_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:64] key,
    input  logic        decrypt,
    input  logic        start,
    output logic [1:48] xkey,
    output logic        load_new_pt,
    output logic        output_ok,
    output logic        busy,
    output logic        done,
    output logic [3:0]  round_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_OUTP,
        S_WAIT
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(OV_LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:28] r_c;
    logic [1:28] r_d;
    logic [3:0]  r_cnt;
    logic [1:0]  r_lat;
    logic        r_dec;
    logic        r_done;

    logic [1:56] w_pc1;
    logic [1:56] w_cd;
    logic [1:48] w_pc2;
    logic        w_enc_dbl;
    logic        w_dec_dbl;
    logic        w_unused_parity;

    // Parity bits never enter the key schedule.
    assign w_unused_parity = ^{key[8], key[16], key[24], key[32],
                               key[40], key[48], key[56], key[64]};

    assign w_pc1 = {key[57], key[49], key[41], key[33], key[25], key[17], key[9],
                    key[1],  key[58], key[50], key[42], key[34], key[26], key[18],
                    key[10], key[2],  key[59], key[51], key[43], key[35], key[27],
                    key[19], key[11], key[3],  key[60], key[52], key[44], key[36],
                    key[63], key[55], key[47], key[39], key[31], key[23], key[15],
                    key[7],  key[62], key[54], key[46], key[38], key[30], key[22],
                    key[14], key[6],  key[61], key[53], key[45], key[37], key[29],
                    key[21], key[13], key[5],  key[28], key[20], key[12], key[4]};

    assign w_cd = {r_c, r_d};

    assign w_pc2 = {w_cd[14], w_cd[17], w_cd[11], w_cd[24], w_cd[1],  w_cd[5],
                    w_cd[3],  w_cd[28], w_cd[15], w_cd[6],  w_cd[21], w_cd[10],
                    w_cd[23], w_cd[19], w_cd[12], w_cd[4],  w_cd[26], w_cd[8],
                    w_cd[16], w_cd[7],  w_cd[27], w_cd[20], w_cd[13], w_cd[2],
                    w_cd[41], w_cd[52], w_cd[31], w_cd[37], w_cd[47], w_cd[55],
                    w_cd[30], w_cd[40], w_cd[51], w_cd[45], w_cd[33], w_cd[48],
                    w_cd[44], w_cd[49], w_cd[39], w_cd[56], w_cd[34], w_cd[53],
                    w_cd[46], w_cd[42], w_cd[50], w_cd[36], w_cd[29], w_cd[32]};

    function automatic logic is_double(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] h, input logic two);
        return two ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] h, input logic two);
        return two ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
    endfunction

    // Leaving round r=r_cnt+1: encrypt uses s(r+1), decrypt uses s(17-r).
    assign w_enc_dbl = is_double({1'b0, r_cnt} + 5'd2);
    assign w_dec_dbl = is_double(5'd16 - {1'b0, r_cnt});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        xkey        = '0;
        load_new_pt = 1'b0;
        output_ok   = 1'b0;
        busy        = 1'b0;
        round_idx   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                xkey        = w_pc2;
                load_new_pt = 1'b1;
                busy        = 1'b1;
                round_idx   = r_cnt;
                w_next      = S_ROUND;
            end
            S_ROUND: begin
                xkey      = w_pc2;
                busy      = 1'b1;
                round_idx = r_cnt;
                if (r_cnt == 4'd15) begin
                    w_next = S_OUTP;
                end
            end
            S_OUTP: begin
                output_ok = 1'b1;
                busy      = 1'b1;
                w_next    = (LAT_INIT == 2'd0) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_lat == 2'd1) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_lat  <= '0;
            r_dec  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= ((r_state == S_OUTP) || (r_state == S_WAIT)) && (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dec <= decrypt;
                        r_cnt <= '0;
                        // Encrypt starts at C1/D1; decrypt starts at C16/D16, which equals C0/D0.
                        if (decrypt) begin
                            r_c <= w_pc1[1:28];
                            r_d <= w_pc1[29:56];
                        end else begin
                            r_c <= rotl(w_pc1[1:28], 1'b0);
                            r_d <= rotl(w_pc1[29:56], 1'b0);
                        end
                    end
                end
                S_LOAD, S_ROUND: begin
                    if (r_cnt != 4'd15) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_dec) begin
                            r_c <= rotr(r_c, w_dec_dbl);
                            r_d <= rotr(r_d, w_dec_dbl);
                        end else begin
                            r_c <= rotl(r_c, w_enc_dbl);
                            r_d <= rotl(r_d, w_enc_dbl);
                        end
                    end
                end
                S_OUTP: begin
                    r_cnt <= '0;
                    r_lat <= LAT_INIT;
                end
                S_WAIT: begin
                    r_lat <= r_lat - 2'd1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_des_key_sequencer.sv
// Directed bench for des_key_sequencer: FIPS key-schedule vector, weak key,
// busy-time start rejection, back-to-back operation and asynchronous abort.
module tb_des_key_sequencer;

    logic        clk;
    logic        reset;
    logic [1:64] key;
    logic        decrypt;
    logic        start;
    logic [1:48] xkey;
    logic        load_new_pt;
    logic        output_ok;
    logic        busy;
    logic        done;
    logic [3:0]  round_idx;

    int unsigned n_checks;
    int unsigned n_fail;

    // K1..K16 for key 133457799BBCDFF1 (standard worked example).
    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_sequencer #(.OV_LATENCY(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .decrypt     (decrypt),
        .start       (start),
        .xkey        (xkey),
        .load_new_pt (load_new_pt),
        .output_ok   (output_ok),
        .busy        (busy),
        .done        (done),
        .round_idx   (round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; key = '0; decrypt = 1'b0;
        #12;
        n_checks++;
        if ({xkey, load_new_pt, output_ok, busy, done, round_idx} !== 57'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h required 0",
                     {xkey, load_new_pt, output_ok, busy, done, round_idx});
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_encrypt();
        key = 64'h133457799BBCDFF1; decrypt = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            n_checks++;
            if (xkey !== ks[k-1]) begin
                n_fail++;
                $display("FAIL enc_xkey cycle %0d got %h required %h", k, xkey, ks[k-1]);
            end
            n_checks++;
            if (load_new_pt !== (k == 1) || round_idx !== 4'(k - 1) || busy !== 1'b1
                || output_ok !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL enc_ctrl cycle %0d got ld=%b idx=%0d busy=%b ok=%b done=%b required ld=%b idx=%0d 1 0 0",
                         k, load_new_pt, round_idx, busy, output_ok, done, (k == 1), k - 1);
            end
            step();
        end
        n_checks++;
        if (output_ok !== 1'b1 || xkey !== 48'd0 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL enc_outp cycle 17 got ok=%b xkey=%h done=%b busy=%b required 1 0 0 1",
                     output_ok, xkey, done, busy);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || output_ok !== 1'b0 || round_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL enc_done cycle 18 got done=%b busy=%b ok=%b idx=%0d required 1 0 0 0",
                     done, busy, output_ok, round_idx);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_done_pulse cycle 19 got %b required 0", done);
        end
    endtask

    task automatic test_decrypt();
        key = 64'h133457799BBCDFF1; decrypt = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        decrypt = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            n_checks++;
            if (xkey !== ks[16-k] || round_idx !== 4'(k - 1)) begin
                n_fail++;
                $display("FAIL dec_xkey cycle %0d got %h idx=%0d required %h idx=%0d",
                         k, xkey, round_idx, ks[16-k], k - 1);
            end
            step();
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_done cycle 18 got %b required 1", done);
        end
        step();
    endtask

    task automatic test_weak_key();
        for (int dir = 0; dir < 2; dir++) begin
            key = 64'h0101010101010101; decrypt = (dir == 1); start = 1'b1;
            step();
            start = 1'b0;
            for (int k = 1; k <= 16; k++) begin
                n_checks++;
                if (xkey !== 48'd0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL weak_xkey dir %0d cycle %0d got %h busy=%b required 0 busy=1",
                             dir, k, xkey, busy);
                end
                step();
            end
            step();
            n_checks++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL weak_done dir %0d got %b required 1", dir, done);
            end
            step();
        end
    endtask

    task automatic test_start_while_busy();
        int unsigned n_done;
        n_done = 0;
        key = 64'h133457799BBCDFF1; decrypt = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 5) begin
                key = 64'hFEDCBA9876543210; decrypt = 1'b1; start = 1'b1;
            end
            if (k == 6) begin
                start = 1'b0;
            end
            if (k <= 16) begin
                n_checks++;
                if (xkey !== ks[k-1]) begin
                    n_fail++;
                    $display("FAIL busy_xkey cycle %0d got %h required %h", k, xkey, ks[k-1]);
                end
            end
            if (k >= 18) begin
                n_checks++;
                if (load_new_pt !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_relaunch cycle %0d got ld=%b busy=%b required 0 0",
                             k, load_new_pt, busy);
                end
            end
            if (done === 1'b1) n_done++;
            step();
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL busy_done_count got %0d required 1", n_done);
        end
    endtask

    task automatic test_back_to_back();
        key = 64'h133457799BBCDFF1; decrypt = 1'b0; start = 1'b1;
        step();
        for (int c = 1; c <= 36; c++) begin
            n_checks++;
            if (load_new_pt !== (c == 1 || c == 19) || done !== (c == 18 || c == 36)) begin
                n_fail++;
                $display("FAIL b2b_strobes cycle %0d got ld=%b done=%b required ld=%b done=%b",
                         c, load_new_pt, done, (c == 1 || c == 19), (c == 18 || c == 36));
            end
            if (c == 19 || c == 34) begin
                n_checks++;
                if (xkey !== ks[c == 19 ? 0 : 15]) begin
                    n_fail++;
                    $display("FAIL b2b_xkey cycle %0d got %h required %h",
                             c, xkey, ks[c == 19 ? 0 : 15]);
                end
            end
            if (c == 36) start = 1'b0;
            step();
        end
        n_checks++;
        if (busy !== 1'b0 || load_new_pt !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop cycle 37 got busy=%b ld=%b required 0 0", busy, load_new_pt);
        end
    endtask

    task automatic test_async_reset();
        key = 64'h133457799BBCDFF1; decrypt = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        n_checks++;
        if (round_idx !== 4'd8) begin
            n_fail++;
            $display("FAIL arst_pre round_idx got %0d required 8", round_idx);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({xkey, load_new_pt, output_ok, busy, done, round_idx} !== 57'd0) begin
            n_fail++;
            $display("FAIL arst_outputs got %h required 0",
                     {xkey, load_new_pt, output_ok, busy, done, round_idx});
        end
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_no_done cycle %0d got done=%b busy=%b required 0 0", c, done, busy);
            end
        end
        test_encrypt();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_weak_key();
        test_start_while_busy();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
